// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment display blocks.
//   state_e    : scan FSM states (IDLE, BLANK, ON)
//   SEG_BLANK  : active-low "all segments off" cathode pattern
//   hex_to_seg : 4-bit hex nibble -> active-low {g,f,e,d,c,b,a}
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low hex font; lowercase b and d keep them distinct from 8 and 0.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h18;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low 7-segment decoder.
// Ports:
//   nib_i   : 4-bit hex value
//   seg_c_o : active-low cathodes {g,f,e,d,c,b,a} (combinational)
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_c_o
);

  always_comb begin
    seg_c_o = hex_to_seg(nib_i);
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with hex decode,
// per-slot blanking guard, PWM brightness, leading-zero suppression and
// per-digit decimal points. Inputs are captured once per frame.
// Ports:
//   clk         : system clock, all logic on posedge
//   reset       : synchronous active-low reset
//   enable      : 1 = scan, 0 = dark and idle
//   digits      : hex nibbles, digits[3:0] is digit 0 (rightmost)
//   dp_mask     : 1 = light decimal point of that digit
//   lz_en       : 1 = suppress leading zeros
//   brightness  : 0 = off, all-ones = full on
//   anode       : active-low digit enables (registered)
//   segs        : active-low cathodes {g,f,e,d,c,b,a} (registered)
//   dp          : active-low decimal point (registered)
//   frame_start : one-cycle pulse as the digit-0 slot of a frame begins
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned SCAN_HZ      = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BRIGHT_W     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*N_DIGITS-1:0]   digits,
  input  logic [N_DIGITS-1:0]     dp_mask,
  input  logic                    lz_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [N_DIGITS-1:0]     anode,
  output logic [6:0]              segs,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = $clog2(N_DIGITS);

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [BRIGHT_W-1:0]     pwm_q;
  logic [4*N_DIGITS-1:0]   snap_digits_q;
  logic [N_DIGITS-1:0]     snap_dp_q;
  logic                    snap_lz_q;

  logic [N_DIGITS-1:0]     anode_q, anode_d;
  logic [6:0]              segs_q, segs_d;
  logic                    dp_q, dp_d;
  logic                    frame_start_q, frame_start_d;

  logic [N_DIGITS-1:0]     hi_zero;
  logic [3:0]              cur_nib;
  logic [6:0]              seg_dec;
  logic                    suppress;
  logic                    dp_sel;
  logic                    lit;
  logic                    digit_on;
  logic                    last_cnt;
  logic                    last_idx;
  logic                    next_is_on;

  seg7_decode u_decode (
    .nib_i   (cur_nib),
    .seg_c_o (seg_dec)
  );

  // Slot decode of the captured frame: which digit, whether it is lit, what it shows.
  always_comb begin
    hi_zero = '0;
    hi_zero[N_DIGITS-1] = (snap_digits_q[4*(N_DIGITS-1) +: 4] == 4'h0);
    // hi_zero[i]: nibbles i..N_DIGITS-1 are all zero
    for (int i = int'(N_DIGITS) - 2; i >= 0; i--) begin
      hi_zero[i] = hi_zero[i+1] && (snap_digits_q[4*i +: 4] == 4'h0);
    end

    cur_nib  = 4'(snap_digits_q >> {idx_q, 2'b00});
    suppress = snap_lz_q && (idx_q != '0) && hi_zero[idx_q];
    dp_sel   = snap_dp_q[idx_q];
    lit      = (brightness == {BRIGHT_W{1'b1}}) || (pwm_q < brightness);
    // A suppressed digit only turns its anode on to show the decimal point.
    digit_on = (state_q == ST_ON) && lit && (!suppress || dp_sel);

    for (int i = 0; i < int'(N_DIGITS); i++) begin
      anode_d[i] = !(digit_on && (idx_q == IDX_W'(i)));
    end
    segs_d        = (digit_on && !suppress) ? seg_dec : SEG_BLANK;
    dp_d          = !(digit_on && dp_sel);
    frame_start_d = (state_q == ST_BLANK) && (cnt_q == '0) && (idx_q == '0);

    last_cnt   = (cnt_q == CNT_W'(DIV - 1));
    last_idx   = (idx_q == IDX_W'(N_DIGITS - 1));
    next_is_on = ((32'(cnt_q) + 32'd1) >= BLANK_CYCLES);
  end

  // Scan FSM, counters, frame snapshot and registered pin drivers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      pwm_q         <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      snap_lz_q     <= 1'b0;
      anode_q       <= '1;
      segs_q        <= SEG_BLANK;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      pwm_q <= pwm_q + BRIGHT_W'(1);
      if (!enable) begin
        state_q       <= ST_IDLE;
        anode_q       <= '1;
        segs_q        <= SEG_BLANK;
        dp_q          <= 1'b1;
        frame_start_q <= 1'b0;
      end else begin
        anode_q       <= anode_d;
        segs_q        <= segs_d;
        dp_q          <= dp_d;
        frame_start_q <= frame_start_d;
        case (state_q)
          ST_IDLE: begin
            state_q       <= ST_BLANK;
            idx_q         <= '0;
            cnt_q         <= '0;
            snap_digits_q <= digits;
            snap_dp_q     <= dp_mask;
            snap_lz_q     <= lz_en;
          end
          ST_BLANK, ST_ON: begin
            if (last_cnt) begin
              cnt_q   <= '0;
              state_q <= (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;
              if (last_idx) begin
                // New frame: capture inputs so a frame never mixes old and new values.
                idx_q         <= '0;
                snap_digits_q <= digits;
                snap_dp_q     <= dp_mask;
                snap_lz_q     <= lz_en;
              end else begin
                idx_q <= idx_q + IDX_W'(1);
              end
            end else begin
              cnt_q   <= cnt_q + CNT_W'(1);
              state_q <= next_is_on ? ST_ON : ST_BLANK;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign anode       = anode_q;
  assign segs        = segs_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux: a frame-phase model predicts the
// pins every cycle, and directed literal checks pin the model down.
module tb_seg7_scan_mux;

  localparam int N     = 4;
  localparam int DIV   = 10;
  localparam int BLANK = 2;
  localparam int FRAME = N * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        lz_en;
  logic [3:0]  brightness;
  logic [3:0]  anode;
  logic [6:0]  segs;
  logic        dp;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  seg7_scan_mux #(
    .N_DIGITS     (4),
    .CLK_HZ       (1000),
    .SCAN_HZ      (100),
    .BLANK_CYCLES (2),
    .BRIGHT_W     (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .digits      (digits),
    .dp_mask     (dp_mask),
    .lz_en       (lz_en),
    .brightness  (brightness),
    .anode       (anode),
    .segs        (segs),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: frame phase = cycles since the frame began; pins show the previous cycle's phase.
  bit         m_active = 1'b0;
  int         m_phase  = 0;
  int         m_pwm    = 0;
  logic [15:0] m_dig   = '0;
  logic [3:0]  m_dpm   = '0;
  bit          m_lz    = 1'b0;
  logic [3:0]  exp_an  = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp  = 1'b1;
  logic        exp_fs  = 1'b0;

  always @(posedge clk) begin : model
    int slot, pos, nib;
    bit supp, lit_m, on;
    exp_an  = 4'hF;
    exp_seg = 7'h7F;
    exp_dp  = 1'b1;
    exp_fs  = 1'b0;
    if (!reset) begin
      m_active = 1'b0;
      m_phase  = 0;
      m_pwm    = 0;
      m_dig    = '0;
      m_dpm    = '0;
      m_lz     = 1'b0;
    end else begin
      if (enable && m_active) begin
        slot   = m_phase / DIV;
        pos    = m_phase % DIV;
        exp_fs = (m_phase == 0);
        if (pos >= BLANK) begin
          nib   = int'((m_dig >> (4 * slot)) & 16'hF);
          supp  = m_lz && (slot > 0) && ((m_dig >> (4 * slot)) == 16'h0);
          lit_m = (brightness == 4'hF) || (m_pwm < int'(brightness));
          on    = lit_m && (!supp || m_dpm[slot]);
          if (on) begin
            exp_an  = 4'(~(32'd1 << slot));
            exp_seg = supp ? 7'h7F : seg_tab[nib];
            exp_dp  = !m_dpm[slot];
          end
        end
      end
      m_pwm = (m_pwm + 1) % 16;
      if (!enable) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        m_active = 1'b1;
        m_phase  = 0;
        m_dig = digits; m_dpm = dp_mask; m_lz = lz_en;
      end else begin
        m_phase = (m_phase + 1) % FRAME;
        if (m_phase == 0) begin
          m_dig = digits; m_dpm = dp_mask; m_lz = lz_en;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (anode !== exp_an || segs !== exp_seg || dp !== exp_dp || frame_start !== exp_fs) begin
        failures++;
        $display("FAIL model_cmp t=%0t anode=%h exp %h segs=%h exp %h dp=%b exp %b fs=%b exp %b",
                 $time, anode, exp_an, segs, exp_seg, dp, exp_dp, frame_start, exp_fs);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit_check(input string nm, input logic [3:0] ea, input logic [6:0] es,
                           input logic ed, input logic ef);
    checks++;
    if (anode !== ea || segs !== es || dp !== ed || frame_start !== ef) begin
      failures++;
      $display("FAIL %s anode=%h exp %h segs=%h exp %h dp=%b exp %b fs=%b exp %b",
               nm, anode, ea, segs, es, dp, ed, frame_start, ef);
    end
  endtask

  task automatic cnt_check(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d exp %0d", nm, got, want);
    end
  endtask

  // Advance to the next negedge showing frame_start, bounded.
  task automatic wait_fs();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_fs timeout got=no_pulse exp pulse");
  endtask

  // Count cycles with any anode low over n consecutive negedges (starting now).
  task automatic count_on(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (anode !== 4'hF) cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int c;
    reset = 1'b0; enable = 1'b1; digits = 16'h3A91; dp_mask = 4'b0000;
    lz_en = 1'b0; brightness = 4'hF;
    step(1);
    chk_on = 1'b1;
    step(2);
    lit_check("reset_state", 4'hF, 7'h7F, 1'b1, 1'b0);

    // Release reset: IDLE cycle, frame_start with blank, one more blank, then digit 0.
    reset = 1'b1;
    step(1); lit_check("rel_idle",     4'hF, 7'h7F, 1'b1, 1'b0);
    step(1); lit_check("rel_fs",       4'hF, 7'h7F, 1'b1, 1'b1);
    step(1); lit_check("rel_blank",    4'hF, 7'h7F, 1'b1, 1'b0);
    step(1); lit_check("rel_first_on", 4'hE, 7'h79, 1'b1, 1'b0);

    // Scan order and decode of 3A91 (now at frame offset 2).
    step(3);  lit_check("scan_d0", 4'hE, 7'h79, 1'b1, 1'b0);
    step(10); lit_check("scan_d1", 4'hD, 7'h18, 1'b1, 1'b0);
    step(10); lit_check("scan_d2", 4'hB, 7'h08, 1'b1, 1'b0);
    step(10); lit_check("scan_d3", 4'h7, 7'h30, 1'b1, 1'b0);
    step(5);  lit_check("frame_period", 4'hF, 7'h7F, 1'b1, 1'b1);

    // Leading-zero suppression with decimal point on the top digit.
    digits = 16'h0050; lz_en = 1'b1; dp_mask = 4'b1000;
    wait_fs();
    step(5);  lit_check("lz_d0", 4'hE, 7'h40, 1'b1, 1'b0);
    step(10); lit_check("lz_d1", 4'hD, 7'h12, 1'b1, 1'b0);
    step(10); lit_check("lz_d2", 4'hF, 7'h7F, 1'b1, 1'b0);
    step(10); lit_check("lz_d3", 4'h7, 7'h7F, 1'b0, 1'b0);
    lz_en = 1'b0;
    wait_fs();
    step(25); lit_check("nolz_d2", 4'hB, 7'h40, 1'b1, 1'b0);
    step(10); lit_check("nolz_d3", 4'h7, 7'h40, 1'b0, 1'b0);

    // Brightness extremes (not snapshotted: effective immediately).
    brightness = 4'h0; dp_mask = 4'b0000; digits = 16'h3A91;
    wait_fs();
    count_on(FRAME, c);
    cnt_check("bright0_dark", c, 0);
    brightness = 4'hF;
    count_on(FRAME, c);
    cnt_check("brightF_on", c, N * (DIV - BLANK));
    brightness = 4'h4;
    step(2 * FRAME);

    // Snapshot: mid-frame digit change must not tear the current frame.
    brightness = 4'hF; digits = 16'h1111;
    wait_fs();
    step(15); lit_check("snap_d1_old", 4'hD, 7'h79, 1'b1, 1'b0);
    digits = 16'h2222;
    step(10); lit_check("snap_d2_old", 4'hB, 7'h79, 1'b1, 1'b0);
    step(10); lit_check("snap_d3_old", 4'h7, 7'h79, 1'b1, 1'b0);
    wait_fs();
    step(5);  lit_check("snap_d0_new", 4'hE, 7'h24, 1'b1, 1'b0);
    step(10); lit_check("snap_d1_new", 4'hD, 7'h24, 1'b1, 1'b0);

    // Disable during ON, then re-enable restarts at digit 0.
    enable = 1'b0;
    step(1); lit_check("en_off", 4'hF, 7'h7F, 1'b1, 1'b0);
    step(2); lit_check("en_off_hold", 4'hF, 7'h7F, 1'b1, 1'b0);
    enable = 1'b1;
    step(1); lit_check("reen_idle", 4'hF, 7'h7F, 1'b1, 1'b0);
    step(1); lit_check("reen_fs",   4'hF, 7'h7F, 1'b1, 1'b1);
    step(3); lit_check("reen_d0",   4'hE, 7'h24, 1'b1, 1'b0);

    // Reset mid-slot.
    step(2);
    reset = 1'b0;
    step(1); lit_check("mid_reset", 4'hF, 7'h7F, 1'b1, 1'b0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
